spike_time_encoder: RTL and testbench
=====================================

SPIKE_TIME_ENCODER -- requirements
Module: spike_time_encoder

Interface
REQ-001 Parameter N, default 8: number of spike channels.
REQ-002 Parameter W, default 3: value width; one gamma cycle is 2^W clock cycles.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: in_values holds a volley to encode.
REQ-006 Port in_ready, output, 1: encoder can accept a volley this cycle.
REQ-007 Port in_values, input, N*W: channel i value at bits [i*W +: W], unsigned spike time.
REQ-008 Port spike_out, output, [0:N-1]: spike lines; idle 1, spike = 1->0 transition.
REQ-009 Port gamma_start, output, 1: high during the first cycle of a gamma (t=0).
REQ-010 Port done, output, 1: one-cycle pulse in the recovery cycle after a gamma.

Function
REQ-011 States SHALL be IDLE, RUN, RECOVER; internal counter t is W bits wide.
REQ-012 in_ready SHALL equal (state==IDLE); it is never asserted in RUN or RECOVER.
REQ-013 Handshake: transfer SHALL occur on a rising edge with in_valid && in_ready; in_values are latched into per-channel registers at that edge.
REQ-014 Transfer SHALL move IDLE->RUN with t=0; in_valid without in_ready SHALL be ignored, with no latching.
REQ-015 In RUN, t SHALL increment by 1 per cycle; when t==2^W-1 the next state SHALL be RECOVER and t SHALL wrap to 0.
REQ-016 RECOVER SHALL last exactly one cycle, then go to IDLE.
REQ-017 Value 2^W-1 (all ones) SHALL mean "no spike": that channel stays 1 for the whole gamma.
REQ-018 In RUN, spike_out[i] SHALL be 0 iff v[i] != 2^W-1 and v[i] <= t; otherwise it is 1.
REQ-019 Each spike line SHALL fall at most once per gamma, with no glitch back to 1 before RECOVER.
REQ-020 In IDLE and RECOVER, all spike_out SHALL be 1.
REQ-021 gamma_start SHALL be 1 only in RUN with t==0; done SHALL be 1 only in RECOVER.
REQ-022 All outputs SHALL be decoded from registers only, with no combinational path from any input to any output.
REQ-023 Latency: a channel with value v SHALL fall in the (v+1)-th cycle after the transfer edge (v=0 falls in the first RUN cycle).
REQ-024 Simultaneous equal values SHALL fall in the same cycle; their order is defined only by time.
REQ-025 Minimum volley period SHALL be 2^W+2 cycles, and back-to-back in_valid SHALL be accepted every 2^W+2 cycles.
REQ-026 A change on in_values after the transfer SHALL NOT affect the gamma in progress.

Reset
REQ-027 While rst is sampled high: the next state SHALL be IDLE, t=0, latched values all 2^W-1, spike_out all 1, gamma_start=0, done=0.
REQ-028 in_ready SHALL be 0 in any cycle where rst is high, and 1 in the first cycle after rst deasserts.
REQ-029 rst asserted mid-RUN or in RECOVER SHALL abort the gamma, with no done pulse; lines return to 1 on the next edge.
REQ-030 in_valid coincident with rst SHALL NOT be accepted.

Verification
REQ-031 Basic encode: N=8, W=3, in_values={0,1,2,3,4,5,6,7} (ch0..ch7) -> ch k falls in RUN cycle t=k for k=0..6; ch7 stays 1; gamma_start in cycle 1 after transfer; done in cycle 9.
REQ-032 Ties and no-spike: all channels value 3 -> all eight lines fall together at t=3; all channels value 7 -> spike_out stays 8'hFF for the full gamma and done still pulses.
REQ-033 Back-to-back: in_valid held high with two different volleys -> second transfer exactly 10 cycles after the first; in_ready low for 9 cycles between transfers.
REQ-034 Input isolation: in_values changed every cycle during RUN -> outputs match the volley latched at transfer.
REQ-035 Reset mid-operation: rst pulsed at t=4 -> next cycle spike_out=8'hFF, state IDLE, no done; a new volley is accepted the cycle after rst deasserts.
REQ-036 Randomized: 1000 random volleys checked against REQ-018 using a reference model of fall time = value.

Source files
------------

// File: rtl/spike_time_encoder.sv
// Time-to-first-spike encoder: latches a volley of W-bit values and emits one
// falling edge per channel at t == value within a 2^W-cycle gamma, then recovers.
module spike_time_encoder #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] in_values,
   output logic [0:N-1]   spike_out,
   output logic           gamma_start,
   output logic           done
);

   typedef enum logic [1:0] {IDLE, RUN, RECOVER} state_t;

   // All-ones doubles as the last gamma tick and the "no spike" code.
   localparam logic [W-1:0] T_MAX = '1;

   state_t         state_q, state_d;
   logic [W-1:0]   t_q, t_d;
   logic           ready_q, ready_d;
   logic [W-1:0]   v_q [N];
   logic [W-1:0]   v_d [N];

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      for (int i = 0; i < N; i++) v_d[i] = v_q[i];

      case (state_q)
         IDLE: begin
            if (in_valid && ready_q) begin
               state_d = RUN;
               t_d     = '0;
               for (int i = 0; i < N; i++) v_d[i] = in_values[i*W +: W];
            end
         end
         RUN: begin
            t_d = t_q + 1'b1;
            if (t_q == T_MAX) state_d = RECOVER;
         end
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Registered so that in_ready stays low in the cycle following a reset edge.
      ready_d = (state_d == IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         ready_q <= 1'b0;
         // NOTE: value registers are reset to the no-spike code, so a stale volley never leaks out.
         for (int i = 0; i < N; i++) v_q[i] <= T_MAX;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         ready_q <= ready_d;
         for (int i = 0; i < N; i++) v_q[i] <= v_d[i];
      end
   end

   always_comb begin
      spike_out = '1;
      if (state_q == RUN) begin
         for (int i = 0; i < N; i++) begin
            if ((v_q[i] != T_MAX) && (v_q[i] <= t_q)) spike_out[i] = 1'b0;
         end
      end
   end

   assign in_ready    = ready_q;
   assign gamma_start = (state_q == RUN) && (t_q == '0);
   assign done        = (state_q == RECOVER);

endmodule

// File: tb/tb_spike_time_encoder.sv
// Self-checking bench for spike_time_encoder: directed scenarios plus random
// volleys compared against a cycle-indexed reference of the encoding rules.
module tb_spike_time_encoder;

   localparam int N = 8;
   localparam int W = 3;
   localparam int G = 1 << W;     // gamma length in cycles
   localparam int L = G + 2;      // cycles observed after a transfer

   typedef logic [W-1:0] vals_t [N];

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N*W-1:0] in_values = '0;
   logic [0:N-1]   spike_out;
   logic           gamma_start;
   logic           done;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [0:N-1] obs_spike [1:L];
   logic         obs_gs    [1:L];
   logic         obs_done  [1:L];
   logic         obs_rdy   [1:L];
   bit           timeout;

   spike_time_encoder #(.N(N), .W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_values   (in_values),
      .spike_out   (spike_out),
      .gamma_start (gamma_start),
      .done        (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [N*W-1:0] pack(input vals_t v);
      logic [N*W-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*W +: W] = v[i];
      return r;
   endfunction

   // Expected spike lines c cycles after the transfer edge: the gamma occupies
   // cycles 1..G with t = c-1; a channel is low once t has reached its value.
   function automatic logic [0:N-1] model_spikes(input vals_t v, input int c);
      logic [0:N-1] e;
      e = '1;
      if (c >= 1 && c <= G) begin
         for (int i = 0; i < N; i++) begin
            if (int'(v[i]) != G - 1 && int'(v[i]) <= c - 1) e[i] = 1'b0;
         end
      end
      return e;
   endfunction

   // Handshakes one volley and records outputs for cycles 1..L after the
   // transfer. With scramble set, inputs are randomised during the gamma.
   task automatic play_gamma(input vals_t v, input bit scramble);
      timeout = 1'b0;
      for (int k = 0; k < 30 && in_ready !== 1'b1; k++) @(negedge clk);
      if (in_ready !== 1'b1) begin
         timeout = 1'b1;
         return;
      end
      in_valid  = 1'b1;
      in_values = pack(v);
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 1; c <= L; c++) begin
         obs_spike[c] = spike_out;
         obs_gs[c]    = gamma_start;
         obs_done[c]  = done;
         obs_rdy[c]   = in_ready;
         if (c < L) begin
            if (scramble) begin
               in_values = (N*W)'($urandom);
               in_valid  = (c < G + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      in_valid  = 1'b1;
      in_values = '0;
      rst       = 1'b1;
      repeat (2) begin
         @(negedge clk);
         total_cnt++;
         if (in_ready !== 1'b0 || spike_out !== '1 || gamma_start !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_state: ready=%b spike=%b gs=%b done=%b, want 0/%b/0/0",
                     in_ready, spike_out, gamma_start, done, {N{1'b1}});
         else pass_cnt++;
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b1 || spike_out !== '1 || gamma_start !== 1'b0)
         $display("FAIL reset_release: ready=%b spike=%b gs=%b, want 1/%b/0",
                  in_ready, spike_out, gamma_start, {N{1'b1}});
      else pass_cnt++;
   endtask

   task automatic test_basic;
      vals_t v;
      for (int i = 0; i < N; i++) v[i] = W'(i);
      play_gamma(v, 1'b0);
      total_cnt++;
      if (timeout !== 1'b0) $display("FAIL basic_handshake: in_ready never rose");
      else pass_cnt++;
      for (int c = 1; c <= L; c++) begin
         total_cnt++;
         if (obs_spike[c] !== model_spikes(v, c) || obs_gs[c] !== (c == 1) ||
             obs_done[c] !== (c == G + 1) || obs_rdy[c] !== (c == L))
            $display("FAIL basic c=%0d: spike=%b gs=%b done=%b rdy=%b, want spike=%b gs=%b done=%b rdy=%b",
                     c, obs_spike[c], obs_gs[c], obs_done[c], obs_rdy[c],
                     model_spikes(v, c), c == 1, c == G + 1, c == L);
         else pass_cnt++;
      end
   endtask

   task automatic test_ties_and_no_spike;
      vals_t v;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < N; i++) v[i] = (pass == 0) ? W'(3) : W'(G - 1);
         play_gamma(v, 1'b0);
         total_cnt++;
         if (timeout !== 1'b0) $display("FAIL ties_handshake pass=%0d: in_ready never rose", pass);
         else pass_cnt++;
         for (int c = 1; c <= L; c++) begin
            total_cnt++;
            if (obs_spike[c] !== model_spikes(v, c) || obs_done[c] !== (c == G + 1) ||
                obs_gs[c] !== (c == 1))
               $display("FAIL ties pass=%0d c=%0d: spike=%b done=%b gs=%b, want spike=%b done=%b gs=%b",
                        pass, c, obs_spike[c], obs_done[c], obs_gs[c],
                        model_spikes(v, c), c == G + 1, c == 1);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_back_to_back;
      vals_t va, vb;
      int low_cnt;
      for (int i = 0; i < N; i++) begin
         va[i] = W'(i);
         vb[i] = W'(G - 2 - (i % (G - 1)));
      end
      for (int k = 0; k < 30 && in_ready !== 1'b1; k++) @(negedge clk);
      in_valid  = 1'b1;
      in_values = pack(va);
      @(negedge clk);
      in_values = pack(vb);
      low_cnt   = 0;
      for (int c = 1; c <= G + 1; c++) begin
         total_cnt++;
         if (spike_out !== model_spikes(va, c) || done !== (c == G + 1))
            $display("FAIL b2b_first c=%0d: spike=%b done=%b, want spike=%b done=%b",
                     c, spike_out, done, model_spikes(va, c), c == G + 1);
         else pass_cnt++;
         if (in_ready === 1'b0) low_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if (in_ready !== 1'b1 || low_cnt != G + 1)
         $display("FAIL b2b_ready: ready=%b low_cycles=%0d, want 1 and %0d", in_ready, low_cnt, G + 1);
      else pass_cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 1; c <= L; c++) begin
         total_cnt++;
         if (spike_out !== model_spikes(vb, c) || gamma_start !== (c == 1) ||
             done !== (c == G + 1) || in_ready !== (c == L))
            $display("FAIL b2b_second c=%0d: spike=%b gs=%b done=%b rdy=%b, want spike=%b gs=%b done=%b rdy=%b",
                     c, spike_out, gamma_start, done, in_ready,
                     model_spikes(vb, c), c == 1, c == G + 1, c == L);
         else pass_cnt++;
         if (c < L) @(negedge clk);
      end
   endtask

   task automatic test_isolation;
      vals_t v;
      for (int i = 0; i < N; i++) v[i] = W'((i * 5 + 1) % G);
      play_gamma(v, 1'b1);
      in_values = '0;
      total_cnt++;
      if (timeout !== 1'b0) $display("FAIL isolation_handshake: in_ready never rose");
      else pass_cnt++;
      for (int c = 1; c <= L; c++) begin
         total_cnt++;
         if (obs_spike[c] !== model_spikes(v, c) || obs_gs[c] !== (c == 1) || obs_done[c] !== (c == G + 1))
            $display("FAIL isolation c=%0d: spike=%b gs=%b done=%b, want spike=%b gs=%b done=%b",
                     c, obs_spike[c], obs_gs[c], obs_done[c], model_spikes(v, c), c == 1, c == G + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid;
      vals_t v;
      for (int i = 0; i < N; i++) v[i] = W'(i % 4);
      for (int k = 0; k < 30 && in_ready !== 1'b1; k++) @(negedge clk);
      in_valid  = 1'b1;
      in_values = pack(v);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      total_cnt++;
      if (spike_out !== model_spikes(v, 5))
         $display("FAIL rst_mid_pre: spike=%b, want %b", spike_out, model_spikes(v, 5));
      else pass_cnt++;
      rst = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (spike_out !== '1 || done !== 1'b0 || gamma_start !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL rst_mid_abort: spike=%b done=%b gs=%b rdy=%b, want %b/0/0/0",
                  spike_out, done, gamma_start, in_ready, {N{1'b1}});
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b1 || done !== 1'b0 || spike_out !== '1)
         $display("FAIL rst_mid_idle: rdy=%b done=%b spike=%b, want 1/0/%b",
                  in_ready, done, spike_out, {N{1'b1}});
      else pass_cnt++;
      for (int i = 0; i < N; i++) v[i] = W'(G - 1 - i);
      play_gamma(v, 1'b0);
      total_cnt++;
      if (timeout !== 1'b0 || obs_gs[1] !== 1'b1)
         $display("FAIL rst_mid_accept: timeout=%b gs=%b, want 0/1", timeout, obs_gs[1]);
      else pass_cnt++;
      for (int c = 1; c <= L; c++) begin
         total_cnt++;
         if (obs_spike[c] !== model_spikes(v, c) || obs_done[c] !== (c == G + 1))
            $display("FAIL rst_mid_after c=%0d: spike=%b done=%b, want spike=%b done=%b",
                     c, obs_spike[c], obs_done[c], model_spikes(v, c), c == G + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_random;
      vals_t v;
      bit    scr;
      for (int n = 0; n < 1000; n++) begin
         for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, G - 1));
         scr = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         play_gamma(v, scr);
         in_valid = 1'b0;
         total_cnt++;
         if (timeout !== 1'b0) begin
            $display("FAIL random_handshake n=%0d: in_ready never rose", n);
            continue;
         end
         pass_cnt++;
         for (int c = 1; c <= L; c++) begin
            total_cnt++;
            if (obs_spike[c] !== model_spikes(v, c) || obs_gs[c] !== (c == 1) ||
                obs_done[c] !== (c == G + 1) || obs_rdy[c] !== (c == L))
               $display("FAIL random n=%0d c=%0d: spike=%b gs=%b done=%b rdy=%b, want spike=%b gs=%b done=%b rdy=%b",
                        n, c, obs_spike[c], obs_gs[c], obs_done[c], obs_rdy[c],
                        model_spikes(v, c), c == 1, c == G + 1, c == L);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_ties_and_no_spike;
      test_back_to_back;
      test_isolation;
      test_reset_mid;
      test_random;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
